spi_fifo_control: RTL
=====================

# spi_fifo_control

Pointer and flag controller for the SPI transmit/receive FIFOs. It sits directly in front of the SPI FIFO memory block and drives that block's write enable, write data, and read/write addresses. It accepts push/pop requests from the SPI shifter or bus side. It tracks occupancy, exposes full/empty/count, and accounts for the memory's one-cycle registered read latency with a `popValid` strobe.

## Interface
Parameters:
- `DATAWIDTH`, 8, word width; must match the attached FIFO memory.
- `DATADEPTH`, 1024, number of words; must be a power of two, ≥ 2.
- `ADDRESSWIDTH`, `$clog2(DATADEPTH)`, pointer width.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of FIFO contents.
- `push` in 1: write request.
- `pushData` in DATAWIDTH: word to write.
- `pop` in 1: read request.
- `memWriteEn` out 1: memory write enable.
- `memDataIn` out DATAWIDTH: memory write data.
- `memWriteAddress` out ADDRESSWIDTH: memory write address.
- `memReadAddress` out ADDRESSWIDTH: memory read address.
- `memDataOut` in DATAWIDTH: registered memory read data.
- `popData` out DATAWIDTH: popped word.
- `popValid` out 1: `popData` valid this cycle.
- `full` out 1: count == DATADEPTH.
- `empty` out 1: count == 0.
- `count` out ADDRESSWIDTH+1: current occupancy.
- `clearErrors` in 1: only with the macro in Configuration.
- `overflow` out 1: only with the macro in Configuration.
- `underflow` out 1: only with the macro in Configuration.

## Operation
- State: `writePointer` and `readPointer` (ADDRESSWIDTH each), `count` (ADDRESSWIDTH+1), `popValid` register.
- Accepted push: `pushAccept = push & !full & !flush`.
- Accepted pop: `popAccept = pop & !empty & !flush`.
- Push while full is dropped. Pop while empty is dropped. A simultaneous pop does not make room for a push in the same cycle.
- Memory drive (combinational):
  - `memWriteEn = pushAccept`
  - `memDataIn = pushData`
  - `memWriteAddress = writePointer`
  - `memReadAddress = readPointer`
- Pointer update: `writePointer` increments on `pushAccept`; `readPointer` increments on `popAccept`. Both wrap modulo DATADEPTH (natural ADDRESSWIDTH overflow).
- Count update:
  - +1 on pushAccept only.
  - −1 on popAccept only.
  - Unchanged when both or neither are accepted.
- `full` and `empty` are decoded from the registered `count`.
- `popValid` register is loaded with `popAccept`.
- `popData = memDataOut` (pass-through). It is meaningful only while `popValid` = 1.
- Flush: pointers := 0, count := 0, popValid := 0. Flush overrides push and pop in the same cycle.
- Reset values: pointers 0, count 0, `empty` 1, `full` 0, `popValid` 0, `overflow`/`underflow` 0.
- Reset is honoured mid-operation at any cycle. Stored memory contents are not cleared; they are unreachable once the pointers are zeroed.

## Timing
- Push accepted in cycle N: word is written at the N edge. `count`/`empty` update after the N edge. The word is poppable from cycle N+1.
- Pop accepted in cycle N:
  - Memory captures `mem[readPointer]` at the N edge.
  - `popValid` = 1 and `popData` = that word during cycle N+1.
  - `readPointer` advances at the same edge.
- Back-to-back pops on consecutive cycles return consecutive words on consecutive cycles, with `popValid` held high.
- Push and pop together at count = 1: write and read addresses differ, no hazard, count stays 1.
- No read-during-write on the same address can occur, because push is rejected when full and pop is rejected when empty.

## Configuration
- `SPI_FIFO_ERROR_FLAGS_EN` defined: `overflow` and `underflow` ports and the `clearErrors` input exist.
  - `overflow` sets sticky on `push & full & !flush`.
  - `underflow` sets sticky on `pop & empty & !flush`.
  - Both flags clear on `clearErrors`; a set event in the same cycle takes priority over the clear.
  - `flush` does not clear the flags. Reset does.
- Not defined: those three ports and their logic are absent. Dropped requests are silently ignored.

## Test plan
Bench uses DATAWIDTH=8, DATADEPTH=4.
- Reset released with no stimulus -> `empty`=1, `full`=0, `count`=0, `popValid`=0, both addresses 0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> `count` 1..4, `full`=1 after the 4th. A 5th push of 0x55 -> no `memWriteEn`, `count` stays 4, `overflow`=1 (macro on).
- From full, pop 4 consecutive cycles -> `popValid` high for 4 cycles starting one cycle later, `popData` 0x11, 0x22, 0x33, 0x44, then `empty`=1. A 5th pop -> `popValid` stays 0, `underflow`=1.
- Wrap-around: push 3 / pop 3, then push 0xA0..0xA3 -> `memWriteAddress` sequence 3, 0, 1, 2. Popping returns 0xA0..0xA3 in order.
- count = 1 with push 0x77 and pop on the same cycle -> old word appears on the next cycle with `popValid`, `count` stays 1, and 0x77 pops next.
- Mid-stream `flush` together with push/pop at count = 3 -> no write, `popValid`=0 next cycle, `count`=0, `empty`=1. Asserting `reset` mid-burst -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/spi_fifo_control.sv
// spi_fifo_control: pointer, occupancy and flag controller for the SPI FIFO memory.
// Latency: pushed word poppable next cycle; popped word appears with popValid one cycle after accept.
// Backpressure: push dropped while full, pop dropped while empty, flush overrides both.
// Optional feature macro: SPI_FIFO_ERROR_FLAGS_EN adds sticky overflow/underflow flags and clearErrors.
module spi_fifo_control #(
  parameter int DATAWIDTH    = 8,
  parameter int DATADEPTH    = 1024,
  parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [DATAWIDTH-1:0]    pushData,
  input  logic                    pop,
  output logic                    memWriteEn,
  output logic [DATAWIDTH-1:0]    memDataIn,
  output logic [ADDRESSWIDTH-1:0] memWriteAddress,
  output logic [ADDRESSWIDTH-1:0] memReadAddress,
  input  logic [DATAWIDTH-1:0]    memDataOut,
  output logic [DATAWIDTH-1:0]    popData,
  output logic                    popValid,
  output logic                    full,
  output logic                    empty,
  output logic [ADDRESSWIDTH:0]   count
`ifdef SPI_FIFO_ERROR_FLAGS_EN
  ,
  input  logic                    clearErrors,
  output logic                    overflow,
  output logic                    underflow
`endif
);

  localparam logic [ADDRESSWIDTH:0] DEPTH_COUNT = (ADDRESSWIDTH+1)'(DATADEPTH);

  logic [ADDRESSWIDTH-1:0] write_pointer;
  logic [ADDRESSWIDTH-1:0] read_pointer;
  logic                    push_accept;
  logic                    pop_accept;

  // Request qualification and memory drive; full/empty come from the registered count,
  // so a pop in the same cycle never frees room for a push.
  always_comb begin
    push_accept     = push & ~full & ~flush;
    pop_accept      = pop & ~empty & ~flush;
    memWriteEn      = push_accept;
    memDataIn       = pushData;
    memWriteAddress = write_pointer;
    memReadAddress  = read_pointer;
    popData         = memDataOut;
  end

  assign full  = (count == DEPTH_COUNT);
  assign empty = (count == '0);

  // Pointers, occupancy and the read-latency strobe; pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
      popValid      <= 1'b0;
    end else if (flush) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
      popValid      <= 1'b0;
    end else begin
      if (push_accept) write_pointer <= write_pointer + ADDRESSWIDTH'(1);
      if (pop_accept)  read_pointer  <= read_pointer + ADDRESSWIDTH'(1);
      if (push_accept && !pop_accept)
        count <= count + (ADDRESSWIDTH+1)'(1);
      else if (pop_accept && !push_accept)
        count <= count - (ADDRESSWIDTH+1)'(1);
      popValid <= pop_accept;
    end
  end

`ifdef SPI_FIFO_ERROR_FLAGS_EN
  // Sticky error flags; a new error event wins over clearErrors, flush leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !flush)      overflow <= 1'b1;
      else if (clearErrors)            overflow <= 1'b0;
      if (pop && empty && !flush)      underflow <= 1'b1;
      else if (clearErrors)            underflow <= 1'b0;
    end
  end
`endif

endmodule
